// File: rtl/branch_unit_if.sv
// rtl/branch_unit_if.sv - request/result bundle between the execute path and the branch unit
interface branch_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] PC;
  logic [XLEN-1:0] Reg0Out;
  logic [XLEN-1:0] Reg1Out;
  logic [XLEN-1:0] imm;
  logic            B;
  logic            BEQ;
  logic            BLT;
  logic            BLTU;
  logic            JMP;
  logic            CALL;
  logic            RET;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] BrPC;
  logic            Branch;
  logic            ras_used;
  logic            ras_miss;

  modport master (
    output in_valid, PC, Reg0Out, Reg1Out, imm,
    output B, BEQ, BLT, BLTU, JMP, CALL, RET, flush, out_ready,
    input  in_ready, out_valid, BrPC, Branch, ras_used, ras_miss
  );

  modport slave (
    input  in_valid, PC, Reg0Out, Reg1Out, imm,
    input  B, BEQ, BLT, BLTU, JMP, CALL, RET, flush, out_ready,
    output in_ready, out_valid, BrPC, Branch, ras_used, ras_miss
  );
endinterface

// File: rtl/branch_unit.sv
// rtl/branch_unit.sv - registered branch resolution with a circular return-address stack
module branch_unit #(
  parameter int XLEN        = 32,
  parameter int RAS_DEPTH   = 8,
  parameter bit RAS_EN      = 1'b1,
  parameter int INSTR_BYTES = 4
) (
  input logic        clk,
  input logic        rst,
  branch_unit_if.slave bus
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    OP_NONE, OP_B, OP_BEQ, OP_BLT, OP_BLTU, OP_JMP, OP_CALL, OP_RET
  } op_t;

  op_t             op;
  logic            taken;
  logic            ras_hit;
  logic            ras_empty;
  logic            accept;
  logic            ready;
  logic [XLEN-1:0] seq_target;
  logic [XLEN-1:0] link;
  logic [XLEN-1:0] ras_top;
  logic [XLEN-1:0] target;

  logic            out_valid_q;
  logic [XLEN-1:0] brpc_q;
  logic            branch_q;
  logic            used_q;
  logic            miss_q;

  always_comb begin
    op = OP_NONE;
    if (bus.B)         op = OP_B;
    else if (bus.BEQ)  op = OP_BEQ;
    else if (bus.BLT)  op = OP_BLT;
    else if (bus.BLTU) op = OP_BLTU;
    else if (bus.JMP)  op = OP_JMP;
    else if (bus.CALL) op = OP_CALL;
    else if (bus.RET)  op = OP_RET;
  end

  always_comb begin
    taken = 1'b0;
    case (op)
      OP_B:    taken = (bus.Reg0Out != bus.Reg1Out);
      OP_BEQ:  taken = (bus.Reg0Out == bus.Reg1Out);
      OP_BLT:  taken = ($signed(bus.Reg0Out) < $signed(bus.Reg1Out));
      OP_BLTU: taken = (bus.Reg0Out < bus.Reg1Out);
      OP_JMP, OP_CALL, OP_RET: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  assign seq_target = bus.PC + bus.imm;
  assign link       = bus.PC + XLEN'(INSTR_BYTES);
  assign ras_hit    = (op == OP_RET) && !ras_empty;
  assign target     = ras_hit ? ras_top : ((op == OP_RET) ? bus.Reg0Out : seq_target);

  // in_ready looks only at the output register, so accept and drain may share an edge
  assign ready        = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && ready && !bus.flush;
  assign bus.in_ready = ready;

  generate
    if (RAS_EN) begin : g_ras
      logic [XLEN-1:0] mem [RAS_DEPTH];
      logic [PW-1:0]   wp;
      logic [CW-1:0]   count;
      logic [PW-1:0]   top_idx;

      assign top_idx   = wp - PW'(1);
      assign ras_top   = mem[top_idx];
      assign ras_empty = (count == '0);

      // Entries carry no reset; count alone decides what is valid
      always_ff @(posedge clk) begin
        if (!rst && accept && op == OP_CALL) mem[wp] <= link;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          wp    <= '0;
          count <= '0;
        end else if (accept && op == OP_CALL) begin
          wp <= wp + PW'(1);
          if (count != CW'(RAS_DEPTH)) count <= count + CW'(1);
        end else if (accept && ras_hit) begin
          wp    <= top_idx;
          count <= count - CW'(1);
        end
      end
    end else begin : g_no_ras
      assign ras_top   = '0;
      assign ras_empty = 1'b1;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      brpc_q      <= '0;
      branch_q    <= 1'b0;
      used_q      <= 1'b0;
      miss_q      <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      brpc_q      <= target;
      branch_q    <= taken;
      used_q      <= ras_hit;
      miss_q      <= RAS_EN && (op == OP_RET) && ras_empty;
    end else if (bus.flush || bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.BrPC      = brpc_q;
  assign bus.Branch    = branch_q;
  assign bus.ras_used  = used_q;
  assign bus.ras_miss  = miss_q;
endmodule

// File: tb/tb_branch_unit.sv
// tb/tb_branch_unit.sv - scoreboard bench for branch_unit with a queue-based RAS reference
module tb_branch_unit;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [31:0] brpc;
    logic        branch;
    logic        used;
    logic        miss;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  res_t        exp_q[$];
  res_t        obs_q[$];
  logic [31:0] ras_m[$];
  logic        exp_valid = 1'b0;

  branch_unit_if #(.XLEN(32)) bus ();

  branch_unit #(.XLEN(32), .RAS_DEPTH(DEPTH), .RAS_EN(1'b1), .INSTR_BYTES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Reference: first set select wins, RAS is a bounded list of link addresses
  function automatic res_t model(logic [6:0] s, logic [31:0] pc, logic [31:0] r0,
                                 logic [31:0] r1, logic [31:0] im);
    res_t r;
    int   idx = 7;
    for (int i = 6; i >= 0; i--) if (s[i]) idx = i;
    r = '{brpc: pc + im, branch: 1'b0, used: 1'b0, miss: 1'b0};
    case (idx)
      0: r.branch = (r0 != r1);
      1: r.branch = (r0 == r1);
      2: r.branch = ($signed(r0) < $signed(r1));
      3: r.branch = (r0 < r1);
      4: r.branch = 1'b1;
      5: begin
        r.branch = 1'b1;
        ras_m.push_back(pc + 32'd4);
        if (ras_m.size() > DEPTH) ras_m.delete(0);
      end
      6: begin
        r.branch = 1'b1;
        if (ras_m.size() > 0) begin
          r.brpc = ras_m.pop_back();
          r.used = 1'b1;
        end else begin
          r.brpc = r0;
          r.miss = 1'b1;
        end
      end
      default: ;
    endcase
    return r;
  endfunction

  task automatic step(input logic v, input logic [6:0] s, input logic [31:0] pc,
                      input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] im,
                      input logic fl, input logic ordy, input logic rs);
    logic acc;
    @(posedge clk);
    #1;
    rst = rs;
    bus.in_valid = v;
    {bus.RET, bus.CALL, bus.JMP, bus.BLTU, bus.BLT, bus.BEQ, bus.B} = s;
    bus.PC = pc;
    bus.Reg0Out = r0;
    bus.Reg1Out = r1;
    bus.imm = im;
    bus.flush = fl;
    bus.out_ready = ordy;
    @(negedge clk);
    #1;
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_valid});
    chk("in_ready", {31'd0, bus.in_ready}, {31'd0, (!exp_valid || ordy)});
    acc = v && (!exp_valid || ordy) && !fl && !rs;
    if (exp_valid && !ordy && (rs || fl)) void'(exp_q.pop_front());
    if (rs) ras_m.delete();
    else if (acc) exp_q.push_back(model(s, pc, r0, r1, im));
    if (rs || fl) exp_valid = 1'b0;
    else if (acc) exp_valid = 1'b1;
    else if (ordy) exp_valid = 1'b0;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 7'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, ordy, 1'b0);
  endtask

  task automatic check_obs(input int idx, input logic [31:0] brpc, input logic branch,
                           input logic used, input logic miss);
    res_t o;
    if (idx >= obs_q.size()) begin
      checks++;
      errors++;
      $display("FAIL obs_missing: got %0d results required index %0d", obs_q.size(), idx);
    end else begin
      o = obs_q[idx];
      chk("dir_BrPC", o.brpc, brpc);
      chk("dir_Branch", {31'd0, o.branch}, {31'd0, branch});
      chk("dir_ras_used", {31'd0, o.used}, {31'd0, used});
      chk("dir_ras_miss", {31'd0, o.miss}, {31'd0, miss});
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_BrPC"}, bus.BrPC, 32'd0);
    chk({tag, "_Branch"}, {31'd0, bus.Branch}, 32'd0);
    chk({tag, "_ras_used"}, {31'd0, bus.ras_used}, 32'd0);
    chk({tag, "_ras_miss"}, {31'd0, bus.ras_miss}, 32'd0);
  endtask

  // Monitor: every presented result must equal the scoreboard head; pop on handshake
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got BrPC %h required no result", bus.BrPC);
        end else begin
          e = exp_q[0];
          chk("BrPC", bus.BrPC, e.brpc);
          chk("Branch", {31'd0, bus.Branch}, {31'd0, e.branch});
          chk("ras_used", {31'd0, bus.ras_used}, {31'd0, e.used});
          chk("ras_miss", {31'd0, bus.ras_miss}, {31'd0, e.miss});
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            obs_q.push_back('{brpc: bus.BrPC, branch: bus.Branch,
                              used: bus.ras_used, miss: bus.ras_miss});
          end
        end
      end
    end
  end

  initial begin
    logic [6:0]  s;
    logic [31:0] pc, r0, r1, im;
    int          k;
    bus.in_valid = 1'b0;
    {bus.RET, bus.CALL, bus.JMP, bus.BLTU, bus.BLT, bus.BEQ, bus.B} = 7'd0;
    bus.PC = '0;
    bus.Reg0Out = '0;
    bus.Reg1Out = '0;
    bus.imm = '0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;

    step(1'b0, 7'd0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 7'd0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b1);
    idle(1'b1);
    check_zero_outputs("reset");

    obs_q.delete();
    for (int i = 0; i < 5; i++)
      step(1'b1, 7'(1 << i), 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 1'b0, 1'b1, 1'b0);
    step(1'b1, 7'b0010000, 32'hFFFF_FFF0, 0, 0, 32'h20, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    check_obs(0, 32'h120, 1'b1, 1'b0, 1'b0);
    check_obs(1, 32'h120, 1'b0, 1'b0, 1'b0);
    check_obs(2, 32'h120, 1'b1, 1'b0, 1'b0);
    check_obs(3, 32'h120, 1'b0, 1'b0, 1'b0);
    check_obs(4, 32'h120, 1'b1, 1'b0, 1'b0);
    check_obs(5, 32'h10, 1'b1, 1'b0, 1'b0);

    obs_q.delete();
    step(1'b1, 7'b0100000, 32'h400, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 7'b1000000, 0, 32'hDEAD, 0, 0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 7'b1000000, 0, 32'hDEAD, 0, 0, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    check_obs(1, 32'h404, 1'b1, 1'b1, 1'b0);
    check_obs(2, 32'hDEAD, 1'b1, 1'b0, 1'b1);

    obs_q.delete();
    for (int i = 0; i < 9; i++)
      step(1'b1, 7'b0100000, 32'(i * 16), 0, 0, 0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++)
      step(1'b1, 7'b1000000, 0, 32'hBEEF, 0, 0, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    for (int i = 0; i < 8; i++) check_obs(9 + i, 32'h84 - 32'(16 * i), 1'b1, 1'b1, 1'b0);
    check_obs(17, 32'hBEEF, 1'b1, 1'b0, 1'b1);

    obs_q.delete();
    step(1'b1, 7'b0100000, 32'h500, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b1, 7'b0100000, 32'h600, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 7'b0100000, 32'h600, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b1, 7'b1000000, 0, 32'h77, 0, 0, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    check_obs(2, 32'h604, 1'b1, 1'b1, 1'b0);
    check_obs(3, 32'h504, 1'b1, 1'b1, 1'b0);
    check_obs(4, 32'h77, 1'b1, 1'b0, 1'b1);

    obs_q.delete();
    step(1'b1, 7'b0100000, 32'h700, 0, 0, 0, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    chk("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
    step(1'b1, 7'b0010000, 32'h10, 0, 0, 32'h4, 1'b0, 1'b1, 1'b0);
    step(1'b0, 7'd0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 7'b1000000, 0, 32'h99, 0, 0, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    check_obs(0, 32'h99, 1'b1, 1'b0, 1'b1);

    obs_q.delete();
    step(1'b1, 7'b0100000, 32'h800, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 7'd0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 7'd0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    check_zero_outputs("stall_reset");
    step(1'b1, 7'b1000000, 0, 32'h55, 0, 0, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    check_obs(0, 32'h55, 1'b1, 1'b0, 1'b1);

    for (int n = 0; n < 3000; n++) begin
      k = $urandom_range(0, 11);
      if (k <= 6) s = 7'(1 << k);
      else if (k <= 8) s = 7'b0100000;
      else if (k <= 10) s = 7'b1000000;
      else s = 7'($urandom());
      pc = $urandom();
      r0 = $urandom();
      k = $urandom_range(0, 2);
      r1 = (k == 0) ? r0 : ((k == 1) ? 32'($urandom_range(0, 3)) : $urandom());
      im = $urandom();
      step($urandom_range(0, 3) != 0, s, pc, r0, r1, im,
           $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 149) == 0);
    end

    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
